// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue between a core and a data memory.
//
// A circular buffer of DEPTH_P entries holds requests in enqueue order.
// The entries move through three regions: queued (not yet issued), in flight
// (issued and waiting for a memory response), and a single response register
// that holds the result until the core consumes it. count_o covers all three.
//
// Ports:
//   clk, reset                    clock; synchronous active-low reset
//   req_valid_i/req_ready_o       core request handshake
//   req_wen_i, req_byte_i         store flag, byte-not-word flag
//   req_addr_i, req_wdata_i       byte address, store data
//   flush_i                       drop every request not yet issued
//   mem_valid_o, mem_yumi_i       head request to memory / memory accepts it
//   mem_wen_o, mem_byte_o         head store / byte flags
//   mem_addr_o, mem_wdata_o       head address / store data
//   mem_resp_valid_i/_data_i      memory response
//   mem_resp_yumi_o               block consumes the memory response
//   resp_valid_o/resp_yumi_i      response to core handshake
//   resp_data_o, resp_is_store_o  load data (0 for stores), store marker
//   count_o                       occupancy
//   err_o                         sticky: response arrived with nothing in flight
//
// Configuration macro: LSU_BYTE_SEXT_EN -- when defined, byte loads are
// sign-extended from bit 7; otherwise they are zero-extended.
module lsu_queue #(
  parameter int DEPTH_P      = 4,
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_wen_i,
  input  logic                        req_byte_i,
  input  logic [ADDR_WIDTH_P-1:0]     req_addr_i,
  input  logic [DATA_WIDTH_P-1:0]     req_wdata_i,
  input  logic                        flush_i,
  output logic                        mem_valid_o,
  output logic                        mem_wen_o,
  output logic                        mem_byte_o,
  output logic [ADDR_WIDTH_P-1:0]     mem_addr_o,
  output logic [DATA_WIDTH_P-1:0]     mem_wdata_o,
  input  logic                        mem_yumi_i,
  input  logic                        mem_resp_valid_i,
  input  logic [DATA_WIDTH_P-1:0]     mem_resp_data_i,
  output logic                        mem_resp_yumi_o,
  output logic                        resp_valid_o,
  output logic [DATA_WIDTH_P-1:0]     resp_data_o,
  output logic                        resp_is_store_o,
  input  logic                        resp_yumi_i,
  output logic [$clog2(DEPTH_P):0]    count_o,
  output logic                        err_o
);

  localparam int PTR_W = $clog2(DEPTH_P);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                    wen;
    logic                    is_byte;
    logic [ADDR_WIDTH_P-1:0] addr;
    logic [DATA_WIDTH_P-1:0] wdata;
  } entry_t;

  entry_t             entry_r [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr_r, iss_ptr_r, ret_ptr_r;
  logic [CNT_W-1:0]   n_q_r, n_if_r, count_r;
  logic               resp_valid_r, resp_is_store_r, err_r;
  logic [DATA_WIDTH_P-1:0] resp_data_r;

  logic               enq_s, head_avail_s, issue_s, if_empty_s, pop_s, consume_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s, iss_ptr_nxt_s, ret_ptr_nxt_s;
  logic [CNT_W-1:0]   n_q_nxt_s, n_if_nxt_s, count_nxt_s;
  logic               resp_valid_nxt_s;
  entry_t             head_s, ret_entry_s;
  logic [7:0]         byte_s;
  logic [DATA_WIDTH_P-1:0] load_data_s;
  logic               load_store_s;

  // Handshake decode and next-state computation for pointers and counters.
  always_comb begin
    head_s       = entry_r[iss_ptr_r];
    ret_entry_s  = entry_r[ret_ptr_r];
    head_avail_s = (n_q_r != {CNT_W{1'b0}});
    if_empty_s   = (n_if_r == {CNT_W{1'b0}});

    req_ready_o     = reset & (count_r < CNT_W'(DEPTH_P)) & ~flush_i;
    mem_valid_o     = reset & head_avail_s & ~flush_i;
    mem_resp_yumi_o = reset & mem_resp_valid_i & (~resp_valid_r | resp_yumi_i | if_empty_s);

    enq_s     = req_valid_i & req_ready_o;
    // The head is taken whenever memory accepts it, even in a flush cycle:
    // an accepted head counts as issued and survives the flush.
    issue_s   = reset & mem_yumi_i & head_avail_s;
    pop_s     = mem_resp_yumi_o & ~if_empty_s;
    consume_s = resp_valid_r & resp_yumi_i;

    iss_ptr_nxt_s = iss_ptr_r + PTR_W'(issue_s);
    ret_ptr_nxt_s = ret_ptr_r + PTR_W'(pop_s);
    n_if_nxt_s    = n_if_r + CNT_W'(issue_s) - CNT_W'(pop_s);

    if (flush_i) begin
      // Un-issued entries vanish: rewind the write pointer to the issue point.
      n_q_nxt_s    = {CNT_W{1'b0}};
      wr_ptr_nxt_s = iss_ptr_nxt_s;
    end else begin
      n_q_nxt_s    = n_q_r + CNT_W'(enq_s) - CNT_W'(issue_s);
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(enq_s);
    end

    resp_valid_nxt_s = pop_s | (resp_valid_r & ~consume_s);
    count_nxt_s      = n_q_nxt_s + n_if_nxt_s + CNT_W'(resp_valid_nxt_s);
  end

  // Format the memory response for the oldest in-flight entry.
  always_comb begin
    byte_s = mem_resp_data_i[7:0];
    if (ret_entry_s.wen) begin
      load_data_s  = {DATA_WIDTH_P{1'b0}};
      load_store_s = 1'b1;
    end else if (ret_entry_s.is_byte) begin
`ifdef LSU_BYTE_SEXT_EN
      load_data_s  = DATA_WIDTH_P'(signed'(byte_s));
`else
      load_data_s  = DATA_WIDTH_P'(byte_s);
`endif
      load_store_s = 1'b0;
    end else begin
      load_data_s  = mem_resp_data_i;
      load_store_s = 1'b0;
    end
  end

  // Request storage; slots are only written on enqueue, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      entry_r[wr_ptr_r] <= '{wen: req_wen_i, is_byte: req_byte_i,
                             addr: req_addr_i, wdata: req_wdata_i};
    end
  end

  // Control state, response register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      iss_ptr_r       <= {PTR_W{1'b0}};
      ret_ptr_r       <= {PTR_W{1'b0}};
      n_q_r           <= {CNT_W{1'b0}};
      n_if_r          <= {CNT_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      resp_valid_r    <= 1'b0;
      resp_data_r     <= {DATA_WIDTH_P{1'b0}};
      resp_is_store_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      iss_ptr_r    <= iss_ptr_nxt_s;
      ret_ptr_r    <= ret_ptr_nxt_s;
      n_q_r        <= n_q_nxt_s;
      n_if_r       <= n_if_nxt_s;
      count_r      <= count_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      if (pop_s) begin
        resp_data_r     <= load_data_s;
        resp_is_store_r <= load_store_s;
      end
      if (mem_resp_yumi_o && if_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign mem_wen_o       = head_s.wen;
  assign mem_byte_o      = head_s.is_byte;
  assign mem_addr_o      = head_s.addr;
  assign mem_wdata_o     = head_s.wdata;
  assign resp_valid_o    = resp_valid_r;
  assign resp_data_o     = resp_data_r;
  assign resp_is_store_o = resp_is_store_r;
  assign count_o         = count_r;
  assign err_o           = err_r;

endmodule
